// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with KMP fallback, Mealy/registered match outputs and a saturating match counter.
// Optional synchronous counter clear is enabled by defining SEQ_PATTERN_DETECTOR_CLEAR_EN.
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       x_in,
    input  logic                       x_valid,
`ifdef SEQ_PATTERN_DETECTOR_CLEAR_EN
    input  logic                       count_clr,
`endif
    output logic                       y_out,
    output logic                       y_reg,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(PAT_LEN)-1:0] state_out
);

    localparam int SW    = $clog2(PAT_LEN);
    localparam int TBL_W = 2 * PAT_LEN * SW;

    localparam logic [SW-1:0]    LAST_STATE = SW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
            $error("seq_pattern_detector: PAT_LEN must be in 2..16");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("seq_pattern_detector: CNT_W must be in 1..32");
        end
    endgenerate

    // Full transition table indexed by {state, bit}. Each entry is the longest
    // pattern prefix (shorter than the whole pattern) that ends the received
    // text "prefix(state) followed by bit", i.e. the KMP automaton.
    function automatic logic [TBL_W-1:0] build_next_tbl();
        logic [TBL_W-1:0]   tbl;
        logic [PAT_LEN-1:0] seq;
        logic               bit_b;
        logic               ok;
        int                 best;
        tbl = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                bit_b = (b == 1);
                seq   = '0;
                for (int j = 0; j <= s; j++) begin
                    seq[j] = (j < s) ? PATTERN[PAT_LEN-1-j] : bit_b;
                end
                best = 0;
                for (int k = 1; k <= s + 1 && k < PAT_LEN; k++) begin
                    ok = 1'b1;
                    for (int i = 0; i < k; i++) begin
                        if (seq[s+1-k+i] != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
                if (s == PAT_LEN - 1 && bit_b == PATTERN[0] && !OVERLAP) best = 0;
                tbl[(s*2+b)*SW +: SW] = SW'(best);
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL = build_next_tbl();

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW:0]   tbl_idx;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        tbl_idx = {state_q, x_in};
        if (x_valid) begin
            state_d = NEXT_TBL[int'(tbl_idx)*SW +: SW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign y_out     = x_valid & ~reset & (state_q == LAST_STATE) & (x_in == PATTERN[0]);
    assign state_out = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            y_reg <= 1'b0;
        end else begin
            y_reg <= y_out;
        end
    end

    // Clear takes priority over a coincident match; the count sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_count <= '0;
`ifdef SEQ_PATTERN_DETECTOR_CLEAR_EN
        end else if (count_clr) begin
            match_count <= '0;
`endif
        end else if (y_out && match_count != CNT_MAX) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule
